// File: rtl/cmd_frame_assembler_pkg.sv
// cmd_pkg: shared definitions for the SPI command frame assembler.
//   - opcode values and their one-hot class bit positions
//   - collector FSM state encoding
//   - opcode_class(): opcode -> one-hot class, 3'b000 for unknown opcodes
package cmd_pkg;

  localparam logic [7:0] OP_READ_00  = 8'h00;
  localparam logic [7:0] OP_CAMWR_01 = 8'h01;
  localparam logic [7:0] OP_READ_02  = 8'h02;
  localparam logic [7:0] OP_CAMWR_03 = 8'h03;
  localparam logic [7:0] OP_CAMWR_04 = 8'h04;
  localparam logic [7:0] OP_CAMWR_05 = 8'h05;
  localparam logic [7:0] OP_CAMWR_06 = 8'h06;
  localparam logic [7:0] OP_MEM_07   = 8'h07;
  localparam logic [7:0] OP_MEM_08   = 8'h08;
  localparam logic [7:0] OP_MEM_09   = 8'h09;
  localparam logic [7:0] OP_MEM_0A   = 8'h0A;
  localparam logic [7:0] OP_CAMWR_0B = 8'h0B;

  localparam int CLS_CAMWRITE = 0;
  localparam int CLS_READ     = 1;
  localparam int CLS_MEM      = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } coll_state_t;

  function automatic logic [2:0] opcode_class(input logic [7:0] op);
    logic [2:0] cls;
    cls = 3'b000;
    case (op)
      OP_CAMWR_01, OP_CAMWR_03, OP_CAMWR_04,
      OP_CAMWR_05, OP_CAMWR_06, OP_CAMWR_0B: cls[CLS_CAMWRITE] = 1'b1;
      OP_READ_00, OP_READ_02:                cls[CLS_READ]     = 1'b1;
      OP_MEM_07, OP_MEM_08,
      OP_MEM_09, OP_MEM_0A:                  cls[CLS_MEM]      = 1'b1;
      default:                               cls = 3'b000;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cmd_frame_assembler_if.sv
// Output stream of the command frame assembler: one held frame behind a
// valid/ready handshake.
//   out_valid   master->slave  held frame available
//   out_ready   slave->master  consumer accepts the held frame
//   instruction master->slave  opcode of the held frame
//   data        master->slave  payload, first payload byte in the MSBs
//   cmd_class   master->slave  one-hot class (bit0 camwrite, bit1 read, bit2 mem)
interface cmd_frame_assembler_if #(
  parameter int DATA_BYTES = 8
) ();

  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              instruction;
  logic [8*DATA_BYTES-1:0] data;
  logic [2:0]              cmd_class;

  modport master (
    output out_valid,
    output instruction,
    output data,
    output cmd_class,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  instruction,
    input  data,
    input  cmd_class,
    output out_ready
  );

endinterface

// File: rtl/cmd_frame_assembler_out_stage.sv
// cmd_out_stage: single-entry output register for completed frames.
// Ports:
//   sysClk, rst_n   clock, async active-low reset
//   i_load          one-cycle strobe: shadow holds a complete frame
//   i_instr/i_data  shadow opcode and payload
//   out_if          master side of the output handshake
//   o_err_opcode    pulse: completed frame had an unknown opcode (dropped)
//   o_err_overrun   pulse: completed frame arrived while output full (dropped)
module cmd_out_stage
  import cmd_pkg::*;
#(
  parameter int DATA_BYTES = 8
) (
  input  logic                    sysClk,
  input  logic                    rst_n,
  input  logic                    i_load,
  input  logic [7:0]              i_instr,
  input  logic [8*DATA_BYTES-1:0] i_data,
  cmd_frame_assembler_if.master   out_if,
  output logic                    o_err_opcode,
  output logic                    o_err_overrun
);

  logic [2:0]              w_class;
  logic                    w_known;
  logic                    w_blocked;
  logic                    r_valid;
  logic [7:0]              r_instr;
  logic [8*DATA_BYTES-1:0] r_data;
  logic [2:0]              r_class;
  logic                    r_err_opcode;
  logic                    r_err_overrun;

  assign w_class   = opcode_class(i_instr);
  assign w_known   = |w_class;
  // A consumer taking the held frame in the completion cycle frees the slot.
  assign w_blocked = r_valid && !out_if.out_ready;

  always_ff @(posedge sysClk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_instr       <= '0;
      r_data        <= '0;
      r_class       <= '0;
      r_err_opcode  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      // Opcode is judged before occupancy, so an unknown opcode never
      // reports as an overrun.
      r_err_opcode  <= i_load && !w_known;
      r_err_overrun <= i_load && w_known && w_blocked;
      if (i_load && w_known && !w_blocked) begin
        r_valid <= 1'b1;
        r_instr <= i_instr;
        r_data  <= i_data;
        r_class <= w_class;
      end else if (r_valid && out_if.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_if.out_valid   = r_valid;
  assign out_if.instruction = r_instr;
  assign out_if.data        = r_data;
  assign out_if.cmd_class   = r_class;
  assign o_err_opcode       = r_err_opcode;
  assign o_err_overrun      = r_err_overrun;

endmodule

// File: rtl/cmd_frame_assembler.sv
// cmd_frame_assembler: collects SPI bytes per chip-select frame into a
// shadow (opcode + DATA_BYTES payload), then hands completed frames to the
// output stage. Flags short, long and stalled frames.
// Ports:
//   sysClk, rst_n            clock, async active-low reset
//   cs_active                synchronised chip select, high for a frame
//   byte_in, rx_valid        received byte and its one-cycle strobe
//   out_if                   master side of the frame output handshake
//   err_short/long/timeout   collector error pulses
//   err_opcode/overrun       output-stage error pulses
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | wait for a cs rising edge; a byte on that edge is byte 0
// ST_COLLECT | byte 0 -> opcode shadow, bytes 1..DATA_BYTES -> payload
// ST_DRAIN   | frame done or abandoned; discard bytes until cs low
module cmd_frame_assembler
  import cmd_pkg::*;
#(
  parameter int DATA_BYTES  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  sysClk,
  input  logic                  rst_n,
  input  logic                  cs_active,
  input  logic [7:0]            byte_in,
  input  logic                  rx_valid,
  cmd_frame_assembler_if.master out_if,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_timeout,
  output logic                  err_opcode,
  output logic                  err_overrun
);

  localparam int BW = $clog2(DATA_BYTES + 1);
  localparam int IW = $clog2(TIMEOUT_CYC);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(DATA_BYTES);
  // The stall fires on the cycle the idle count would reach TIMEOUT_CYC-1.
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYC - 2);

  coll_state_t             r_state;
  coll_state_t             w_next;
  logic                    r_cs_q;
  logic [BW-1:0]           r_byte_cnt;
  logic [IW-1:0]           r_idle_cnt;
  logic [7:0]              r_sh_instr;
  logic [8*DATA_BYTES-1:0] r_sh_data;
  logic                    r_frame_done;
  logic                    r_long_seen;
  logic                    r_err_short;
  logic                    r_err_long;
  logic                    r_err_timeout;

  logic                    w_cs_rise;
  logic                    w_last_byte;
  logic                    w_stall;
  logic                    w_capture;
  logic [BW-1:0]           w_byte_idx;
  logic                    w_complete;
  logic                    w_short;
  logic                    w_long;
  logic                    w_timeout;

  assign w_cs_rise   = cs_active && !r_cs_q;
  assign w_last_byte = rx_valid && (r_byte_cnt == LAST_BYTE);
  assign w_stall     = !rx_valid && (r_idle_cnt == IDLE_LIMIT);

  always_ff @(posedge sysClk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_cs_rise) w_next = ST_COLLECT;
      ST_COLLECT: begin
        if (!cs_active)                 w_next = ST_IDLE;
        else if (w_last_byte || w_stall) w_next = ST_DRAIN;
      end
      ST_DRAIN:   if (!cs_active) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_capture  = 1'b0;
    w_byte_idx = '0;
    w_complete = 1'b0;
    w_short    = 1'b0;
    w_long     = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: w_capture = w_cs_rise && rx_valid;
      ST_COLLECT: begin
        if (!cs_active) begin
          w_short = (r_byte_cnt != '0);
        end else begin
          w_capture  = rx_valid;
          w_byte_idx = r_byte_cnt;
          w_complete = w_last_byte;
          w_timeout  = w_stall;
        end
      end
      ST_DRAIN: w_long = cs_active && rx_valid && !r_long_seen;
      default: ;
    endcase
  end

  always_ff @(posedge sysClk or negedge rst_n) begin
    if (!rst_n) begin
      // cs counts as already high so a reset inside a frame waits for cs low.
      r_cs_q        <= 1'b1;
      r_byte_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_sh_instr    <= '0;
      r_sh_data     <= '0;
      r_frame_done  <= 1'b0;
      r_long_seen   <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_cs_q        <= cs_active;
      r_frame_done  <= w_complete;
      r_err_short   <= w_short;
      r_err_long    <= w_long;
      r_err_timeout <= w_timeout;

      if (r_state != ST_COLLECT)  r_byte_cnt <= w_capture ? BW'(1) : '0;
      else if (w_capture)         r_byte_cnt <= r_byte_cnt + 1'b1;

      if (r_state != ST_COLLECT || rx_valid) r_idle_cnt <= '0;
      else                                   r_idle_cnt <= r_idle_cnt + 1'b1;

      if (w_capture) begin
        if (w_byte_idx == '0) r_sh_instr <= byte_in;
        for (int k = 1; k <= DATA_BYTES; k++) begin
          if (w_byte_idx == BW'(k)) r_sh_data[8*(DATA_BYTES-k+1)-1 -: 8] <= byte_in;
        end
      end

      // A stalled frame is treated as already reported, so its trailing
      // bytes do not also raise err_long.
      if (r_state == ST_IDLE)       r_long_seen <= 1'b0;
      else if (w_long || w_timeout) r_long_seen <= 1'b1;
    end
  end

  assign err_short   = r_err_short;
  assign err_long    = r_err_long;
  assign err_timeout = r_err_timeout;

  cmd_out_stage #(
    .DATA_BYTES (DATA_BYTES)
  ) u_out_stage (
    .sysClk        (sysClk),
    .rst_n         (rst_n),
    .i_load        (r_frame_done),
    .i_instr       (r_sh_instr),
    .i_data        (r_sh_data),
    .out_if        (out_if),
    .o_err_opcode  (err_opcode),
    .o_err_overrun (err_overrun)
  );

endmodule
